alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 202 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: ADD/NAND/SUB with conditional execute, C/Z flags, valid/ready.
// Define ALU_SEQ_MUL_EN to add an iterative shift-add multiplier on opcode 100.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [2:0]       op,
    input  logic [1:0]       cond,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             wr_en,
    output logic             carry,
    output logic             zero,
    output logic             compare,
    output logic             busy
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_NAND = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b100;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             wr_en_q, wr_en_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             compare_q, compare_d;
    logic             busy_q;

    logic             accept;
    logic             cond_ok;
    logic             legal;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] nand_r;

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = $clog2(WIDTH) + 1;

    logic               busy_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_nx;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
`endif

    assign in_ready = !busy_q && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    assign sum    = {1'b0, in1} + {1'b0, in2};
    assign diff   = in1 - in2;
    assign nand_r = ~(in1 & in2);

    always_comb begin
        cond_ok = 1'b1;
        case (cond)
            2'b01:   cond_ok = carry_q;
            2'b10:   cond_ok = zero_q;
            default: cond_ok = 1'b1;
        endcase
    end

    always_comb begin
        legal = 1'b0;
        case (op)
            OP_ADD, OP_NAND, OP_SUB: legal = 1'b1;
`ifdef ALU_SEQ_MUL_EN
            OP_MUL:                  legal = 1'b1;
`endif
            default:                 legal = 1'b0;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        out_d       = out_q;
        wr_en_d     = wr_en_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        compare_d   = compare_q;
`ifdef ALU_SEQ_MUL_EN
        busy_d      = busy_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        acc_nx      = acc_q + (mplier_q[0] ? mcand_q : '0);
        acc_d       = acc_q;
`endif
        if (accept) begin
            compare_d   = (in1 == in2);
            out_valid_d = 1'b1;
            wr_en_d     = 1'b0;
            if (!legal) begin
                out_d = '0;
            end else if (!cond_ok) begin
                out_d = in1;
            end else begin
                unique case (1'b1)
                    (op == OP_ADD): begin
                        out_d   = sum[WIDTH-1:0];
                        carry_d = sum[WIDTH];
                        zero_d  = (sum[WIDTH-1:0] == '0);
                        wr_en_d = 1'b1;
                    end
                    (op == OP_NAND): begin
                        out_d   = nand_r;
                        zero_d  = (nand_r == '0);
                        wr_en_d = 1'b1;
                    end
                    (op == OP_SUB): begin
                        out_d   = diff;
                        carry_d = (in1 >= in2);
                        zero_d  = (diff == '0);
                        wr_en_d = 1'b1;
                    end
                    default: begin
`ifdef ALU_SEQ_MUL_EN
                        // Result and flags stay put until the last partial product.
                        out_valid_d = 1'b0;
                        wr_en_d     = wr_en_q;
                        busy_d      = 1'b1;
                        acc_d       = '0;
                        mcand_d     = {{WIDTH{1'b0}}, in1};
                        mplier_d    = in2;
                        cnt_d       = '0;
`endif
                    end
                endcase
            end
        end
`ifdef ALU_SEQ_MUL_EN
        if (busy_q) begin
            acc_d    = acc_nx;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
                busy_d      = 1'b0;
                out_valid_d = 1'b1;
                out_d       = acc_nx[WIDTH-1:0];
                carry_d     = |acc_nx[2*WIDTH-1:WIDTH];
                zero_d      = (acc_nx[WIDTH-1:0] == '0);
                wr_en_d     = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            wr_en_q     <= 1'b0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            compare_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            wr_en_q     <= wr_en_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            compare_q   <= compare_d;
        end
    end

`ifdef ALU_SEQ_MUL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end
`else
    assign busy_q = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign wr_en     = wr_en_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign compare   = compare_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=16), hand-computed expectations.
// MUL vectors run when ALU_SEQ_MUL_EN is defined; otherwise op 100 is checked as illegal.
module tb_alu_seq;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [2:0]   op;
    logic [1:0]   cond;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         wr_en;
    logic         carry;
    logic         zero;
    logic         compare;
    logic         busy;

    int errors = 0;
    int checks = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .op        (op),
        .cond      (cond),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .wr_en     (wr_en),
        .carry     (carry),
        .zero      (zero),
        .compare   (compare),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one request at a negedge, let it be accepted, return at next negedge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [1:0] c);
        op       = o;
        in1      = a;
        in2      = b;
        cond     = c;
        in_valid = 1'b1;
        check("in_ready_before_issue", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic expect_res(input string tag, input logic [W-1:0] o,
                              input logic w, input logic c, input logic z,
                              input logic cmp);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_out"}, out, o);
        check({tag, "_wr_en"}, wr_en, w);
        check({tag, "_carry"}, carry, c);
        check({tag, "_zero"}, zero, z);
        check({tag, "_cmp"}, compare, cmp);
    endtask

    task automatic expect_reset(input string tag);
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_out"}, out, '0);
        check({tag, "_wr_en"}, wr_en, 1'b0);
        check({tag, "_carry"}, carry, 1'b0);
        check({tag, "_zero"}, zero, 1'b0);
        check({tag, "_cmp"}, compare, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_in_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in1       = '0;
        in2       = '0;
        op        = 3'b000;
        cond      = 2'b00;
        out_ready = 1'b1;
        #12;
        expect_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        issue(3'b000, 16'hFFFF, 16'h0001, 2'b00);
        expect_res("add_wrap", 16'h0000, 1, 1, 1, 0);
        issue(3'b000, 16'h0002, 16'h0003, 2'b01);
        expect_res("add_c_true", 16'h0005, 1, 0, 0, 0);
        issue(3'b000, 16'h0001, 16'h0001, 2'b01);
        expect_res("add_c_false", 16'h0001, 0, 0, 0, 1);

        issue(3'b000, 16'hFFFF, 16'h0001, 2'b00);
        expect_res("add_wrap2", 16'h0000, 1, 1, 1, 0);
        issue(3'b001, 16'hFFFF, 16'hFFFF, 2'b00);
        expect_res("nand_ff", 16'h0000, 1, 1, 1, 1);
        issue(3'b001, 16'hF0F0, 16'h3C3C, 2'b11);
        expect_res("nand_mix", 16'hCFCF, 1, 1, 0, 0);

        issue(3'b010, 16'h0005, 16'h0003, 2'b00);
        expect_res("sub_pos", 16'h0002, 1, 1, 0, 0);
        issue(3'b010, 16'h0003, 16'h0005, 2'b00);
        expect_res("sub_neg", 16'hFFFE, 1, 0, 0, 0);
        issue(3'b010, 16'h0007, 16'h0007, 2'b00);
        expect_res("sub_eq", 16'h0000, 1, 1, 1, 1);

        issue(3'b000, 16'h0001, 16'h0002, 2'b10);
        expect_res("add_z_true", 16'h0003, 1, 0, 0, 0);
        issue(3'b001, 16'h1234, 16'h0000, 2'b10);
        expect_res("nand_z_false", 16'h1234, 0, 0, 0, 0);

        issue(3'b000, 16'hFFFF, 16'h0001, 2'b00);
        expect_res("add_wrap3", 16'h0000, 1, 1, 1, 0);
        issue(3'b011, 16'h0055, 16'h0055, 2'b00);
        expect_res("illegal_011", 16'h0000, 0, 1, 1, 1);
        issue(3'b111, 16'h0001, 16'h0002, 2'b00);
        expect_res("illegal_111", 16'h0000, 0, 1, 1, 0);

`ifdef ALU_SEQ_MUL_EN
        issue(3'b100, 16'h0100, 16'h0100, 2'b00);
        for (int i = 0; i < W; i++) begin
            check("mul_busy", busy, 1'b1);
            check("mul_not_valid", out_valid, 1'b0);
            check("mul_in_ready", in_ready, 1'b0);
            @(negedge clk);
        end
        check("mul_busy_done", busy, 1'b0);
        expect_res("mul_big", 16'h0000, 1, 1, 1, 1);
        issue(3'b100, 16'h0003, 16'h0005, 2'b00);
        repeat (W) @(negedge clk);
        expect_res("mul_small", 16'h000F, 1, 0, 0, 0);
        issue(3'b100, 16'h0009, 16'h0002, 2'b10);
        check("mul_cond_false_busy", busy, 1'b0);
        expect_res("mul_cond_false", 16'h0009, 0, 0, 0, 0);
`else
        issue(3'b100, 16'h0003, 16'h0005, 2'b00);
        check("mul_off_busy", busy, 1'b0);
        expect_res("mul_off", 16'h0000, 0, 1, 1, 0);
`endif

        issue(3'b000, 16'h0010, 16'h0020, 2'b00);
        expect_res("bp_load", 16'h0030, 1, 0, 0, 0);
        out_ready = 1'b0;
        op        = 3'b000;
        in1       = 16'h0001;
        in2       = 16'h0001;
        cond      = 2'b00;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 1'b0);
            expect_res("bp_hold", 16'h0030, 1, 0, 0, 0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        expect_res("bp_next", 16'h0002, 1, 0, 0, 1);
        @(negedge clk);
        check("drain_valid", out_valid, 1'b0);

`ifdef ALU_SEQ_MUL_EN
        issue(3'b100, 16'h0003, 16'h0005, 2'b00);
        repeat (7) @(negedge clk);
        check("mul_mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        expect_reset("mul_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            check("mul_rst_no_valid", out_valid, 1'b0);
        end
`endif

        issue(3'b010, 16'h0009, 16'h0004, 2'b00);
        out_ready = 1'b0;
        expect_res("pre_rst", 16'h0005, 1, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_reset("async_rst");
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        issue(3'b000, 16'h0004, 16'h0004, 2'b00);
        expect_res("post_rst", 16'h0008, 1, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
